// File: rtl/mmio_decoder.sv
// mmio_decoder: splits the CPU address space into RAM (addr MSB = 0) and a
// small memory-mapped I/O bank (addr MSB = 1).
// I/O offsets:
//   0 .. NUM_OUT-1 : output registers, readable and writable
//   NUM_OUT        : input port after a 2-flop synchroniser, read-only
//   NUM_OUT+1      : sticky rising-edge capture, write 1 to clear a bit
// Read data comes back one cycle after the address, which matches the
// latency of the registered RAM.
module mmio_decoder #(
    parameter int                ADDR_W  = 6,
    parameter int                DATA_W  = 8,
    parameter int                MEM_A   = 12,
    parameter int                NUM_OUT = 4,
    parameter logic [DATA_W-1:0] OUT_RST = '0
) (
    input  logic                      clk,
    input  logic                      reset_l,
    input  logic                      rw,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [DATA_W-1:0]         cpu_wdata,
    output logic [DATA_W-1:0]         cpu_rdata,
    output logic                      ram_cs,
    output logic [MEM_A-1:0]          ram_addr,
    input  logic [DATA_W-1:0]         ram_rdata,
    output logic [NUM_OUT*DATA_W-1:0] out_port,
    output logic [NUM_OUT-1:0]        wr_pulse,
    input  logic [DATA_W-1:0]         in_port
);

    localparam int OFF_W = ADDR_W - 1;
    localparam logic [OFF_W-1:0] IN_OFF   = OFF_W'(NUM_OUT);
    localparam logic [OFF_W-1:0] EDGE_OFF = OFF_W'(NUM_OUT + 1);

    logic              io_sel;
    logic [OFF_W-1:0]  off;
    logic              wr_en;
    logic [NUM_OUT-1:0] wr_hit;
    logic [DATA_W-1:0] edge_clr;
    logic [DATA_W-1:0] edge_rise;
    logic [DATA_W-1:0] rd_val;

    logic [DATA_W-1:0] out_q [NUM_OUT];
    logic [NUM_OUT-1:0] wr_pulse_q;
    logic [DATA_W-1:0] sync1_q;
    logic [DATA_W-1:0] sync2_q;
    logic [DATA_W-1:0] sync3_q;
    logic [DATA_W-1:0] edge_q;
    logic              rd_io_q;
    logic [DATA_W-1:0] io_rdata_q;

    assign io_sel   = addr[ADDR_W-1];
    assign off      = addr[ADDR_W-2:0];
    assign wr_en    = io_sel & ~rw;
    assign ram_cs   = ~io_sel;
    assign ram_addr = MEM_A'(off);

    // Rising edges are seen between synchroniser stage 2 and an extra delay flop
    assign edge_rise = sync2_q & ~sync3_q;
    assign edge_clr  = (wr_en && off == EDGE_OFF) ? cpu_wdata : '0;

    // Per-channel write decode and read-data select; unmapped offsets read 0
    always_comb begin
        wr_hit = '0;
        rd_val = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            if (off == OFF_W'(k)) begin
                wr_hit[k] = wr_en;
                rd_val    = out_q[k];
            end
        end
        if (off == IN_OFF)   rd_val = sync2_q;
        if (off == EDGE_OFF) rd_val = edge_q;
    end

    // Flatten the output registers onto the channel bus
    always_comb begin
        out_port = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_port[k*DATA_W +: DATA_W] = out_q[k];
        end
    end

    // Output registers and their one-cycle write strobes
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int k = 0; k < NUM_OUT; k++) out_q[k] <= OUT_RST;
            wr_pulse_q <= '0;
        end else begin
            for (int k = 0; k < NUM_OUT; k++) begin
                if (wr_hit[k]) out_q[k] <= cpu_wdata;
            end
            wr_pulse_q <= wr_hit;
        end
    end

    // Input synchroniser, edge-delay flop and sticky edge register (set beats clear)
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            sync1_q <= '0;
            sync2_q <= '0;
            sync3_q <= '0;
            edge_q  <= '0;
        end else begin
            sync1_q <= in_port;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= (edge_q & ~edge_clr) | edge_rise;
        end
    end

    // Registered read select and I/O read data; captured on every bus cycle
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            rd_io_q    <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            rd_io_q    <= io_sel;
            io_rdata_q <= rd_val;
        end
    end

    assign wr_pulse  = wr_pulse_q;
    assign cpu_rdata = rd_io_q ? io_rdata_q : ram_rdata;

endmodule
